mt_untemper_recover: RTL and testbench
======================================

// Module: mt_untemper_recover
// PURPOSE
//  Consumer-side inverse of the Mersenne Twister output stage. Accepts tempered
//  32-bit outputs over a valid/ready handshake and undoes the four tempering steps
//  with one iteration per clock. Emits the recovered raw state word with its state
//  index 0..N-1. Used to clone/check generator state in test and monitor paths.
// PARAMETERS
//  N  624          state words per full recovery (counter modulus)
//  U  11           tempering shift 1 (right); D mask fixed to 32'hFFFFFFFF
//  S  7            tempering shift 2 (left)
//  B  32'h9D2C5680 tempering mask 2
//  T  15           tempering shift 3 (left)
//  C  32'hEFC60000 tempering mask 3
//  L  18           tempering shift 4 (right)
// PORTS
//  clk        in   1    clock, all state updates on rising edge
//  rst        in   1    asynchronous, active-high reset
//  restart    in   1    synchronous clear: abort word in flight, index<=0, full<=0
//  in_valid   in   1    in_data holds a tempered output
//  in_ready   out  1    block can accept a word (high only in IDLE)
//  in_data    in   32   tempered value (generator r_num)
//  out_valid  out  1    out_data/out_index valid, held until out_ready
//  out_ready  in   1    downstream accepts recovered word
//  out_data   out  32   recovered untempered state word
//  out_index  out  IW   state index of out_data, IW = $clog2(N)
//  full       out  1    sticky: N words emitted since reset/restart
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, in_ready=1, out_valid=0, out_data=0,
//   out_index=0, full=0, working regs x/y=0. restart has the same effect
//   synchronously and has priority over all handshakes in that cycle.
//  FSM: IDLE -> UNDO_L -> UNDO_T -> UNDO_S -> UNDO_U -> OUT -> IDLE.
//  IDLE: on in_valid&&in_ready, x<=in_data, y<=in_data, iter<=0, go UNDO_L.
//  Iteration counts K(k)=ceil(32/k)-1, min 1; defaults L:1 T:2 S:4 U:2 (9 total).
//   Each iteration is one cycle; last iteration of a stage loads x<=new y and
//   moves to the next stage with iter<=0.
//  UNDO_L: y <= x ^ (y >> L).       UNDO_T: y <= x ^ ((y << T) & C).
//  UNDO_S: y <= x ^ ((y << S) & B). UNDO_U: y <= x ^ (y >> U).
//  All shifts logical, 32-bit, bits shifted out discarded; no width growth.
//  Latency: out_valid rises exactly 9 edges (defaults) after the accepting edge.
//  OUT: out_valid=1; out_data/out_index stable while out_ready=0 (no drop/change).
//   On out_valid&&out_ready: go IDLE; out_index<=out_index+1, wraps N-1 -> 0;
//   when the emitted word had index N-1, full<=1 (stays 1 across wrap).
//  in_ready=0 in every non-IDLE state; min throughput 1 word / 11 cycles.
//  in_data changes while in_ready=0 are ignored; input captured only at accept.
//  restart during UNDO_* or OUT: word discarded, no out handshake completes.
//  rst mid-operation: immediate return to reset values, no partial output.
// TESTING
//  1. in_data=32'h00400091 -> out_data=32'h00000001, out_index=0, 9 edges latency.
//  2. in_data=32'h00000000 -> out_data=32'h00000000; in_data=32'hFFFFFFFF vs model.
//  3. 1000 random x, feed temper(x) -> out_data==x each; out_index counts 0..999 mod N.
//  4. Hold out_ready=0 for 20 cycles -> out_valid/out_data/out_index stable, in_ready=0.
//  5. Emit 624 words -> full=1 after index 623 handshake, next out_index=0, full stays 1.
//  6. restart asserted in UNDO_S, then rst asserted in OUT -> no output, index=0, full=0.

Source files
------------

// File: rtl/mt_untemper_recover_if.sv
// mt_untemper_recover_if: tempered-word input channel and recovered-word output channel
interface mt_untemper_recover_if #(parameter int N = 624);
   localparam int IW = $clog2(N);
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic [IW-1:0] out_index;
   logic          full;
   modport master(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_index, full);
   modport slave(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_index, full);
endinterface

// File: rtl/mt_untemper_recover.sv
// mt_untemper_recover: inverts Mersenne Twister tempering one fixed-point iteration per clock
module mt_untemper_recover #(
   parameter int          N = 624,
   parameter int          U = 11,
   parameter int          S = 7,
   parameter logic [31:0] B = 32'h9D2C5680,
   parameter int          T = 15,
   parameter logic [31:0] C = 32'hEFC60000,
   parameter int          L = 18
) (
   input logic clk,
   input logic rst,
   input logic restart,
   mt_untemper_recover_if.master bus
);
   localparam int IW = $clog2(N);
   function automatic int iters(int k);
      return ((32 + k - 1) / k - 1 < 1) ? 1 : (32 + k - 1) / k - 1;
   endfunction
   localparam int KL = iters(L);
   localparam int KT = iters(T);
   localparam int KS = iters(S);
   localparam int KU = iters(U);
   typedef enum logic [2:0] {IDLE, UNDO_L, UNDO_T, UNDO_S, UNDO_U, OUT} state_t;
   state_t        state, state_n, stage_next;
   logic [31:0]   x, x_n, y, y_n, y_step;
   logic [4:0]    iter, iter_n, k_last;
   logic [IW-1:0] idx, idx_n;
   logic          full, full_n, last, idx_top;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
         iter  <= '0;
         idx   <= '0;
         full  <= 1'b0;
      end else begin
         state <= state_n;
         x     <= x_n;
         y     <= y_n;
         iter  <= iter_n;
         idx   <= idx_n;
         full  <= full_n;
      end
   // Each stage iterates y toward the fixed point; x holds the stage's input word.
   always_comb begin
      y_step = (state == UNDO_L) ? x ^ (y >> L) :
               (state == UNDO_T) ? x ^ ((y << T) & C) :
               (state == UNDO_S) ? x ^ ((y << S) & B) : x ^ (y >> U);
      k_last = (state == UNDO_L) ? 5'(KL - 1) :
               (state == UNDO_T) ? 5'(KT - 1) :
               (state == UNDO_S) ? 5'(KS - 1) : 5'(KU - 1);
      stage_next = (state == UNDO_L) ? UNDO_T :
                   (state == UNDO_T) ? UNDO_S :
                   (state == UNDO_S) ? UNDO_U : OUT;
      last    = iter == k_last;
      idx_top = idx == IW'(N - 1);
      state_n = state;
      x_n     = x;
      y_n     = y;
      iter_n  = iter;
      idx_n   = idx;
      full_n  = full;
      if (restart) begin
         state_n = IDLE;
         x_n     = '0;
         y_n     = '0;
         iter_n  = '0;
         idx_n   = '0;
         full_n  = 1'b0;
      end else if (state == IDLE) begin
         if (bus.in_valid) begin
            x_n     = bus.in_data;
            y_n     = bus.in_data;
            iter_n  = '0;
            state_n = UNDO_L;
         end
      end else if (state == OUT) begin
         if (bus.out_ready) begin
            state_n = IDLE;
            idx_n   = idx_top ? '0 : idx + 1'b1;
            full_n  = full | idx_top;
         end
      end else begin
         y_n     = y_step;
         x_n     = last ? y_step : x;
         iter_n  = last ? 5'd0 : iter + 5'd1;
         state_n = last ? stage_next : state;
      end
   end
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == OUT;
   assign bus.out_data  = x;
   assign bus.out_index = idx;
   assign bus.full      = full;
endmodule

// File: tb/tb_mt_untemper_recover.sv
// tb_mt_untemper_recover: directed and tempered-random vectors checked through a scoreboard
module tb_mt_untemper_recover;
   localparam int N = 624;
   typedef struct {
      logic [31:0] data;
      int          idx;
   } exp_t;
   logic clk = 1'b0;
   logic rst;
   logic restart;
   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   emitted = 0;
   int   exp_idx = 0;
   int   lat;
   always #5 clk = ~clk;
   mt_untemper_recover_if #(.N(N)) bus();
   mt_untemper_recover #(.N(N)) dut(.clk(clk), .rst(rst), .restart(restart), .bus(bus));

   function automatic logic [31:0] temper(logic [31:0] v);
      logic [31:0] t;
      t = v;
      t = t ^ (t >> 11);
      t = t ^ ((t << 7) & 32'h9D2C5680);
      t = t ^ ((t << 15) & 32'hEFC60000);
      t = t ^ (t >> 18);
      return t;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(logic [31:0] raw);
      sb.push_back('{raw, exp_idx});
      exp_idx = (exp_idx + 1) % N;
   endtask

   task automatic send(logic [31:0] t);
      int n = 0;
      while (!bus.in_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n == 100) check("in_ready wait", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = t;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n == 200) check("drain", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst || restart) emitted = 0;
      else if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected output: got data %h index %0d, expected none", bus.out_data, bus.out_index);
         end else begin
            e = sb.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_index", 32'(bus.out_index), 32'(e.idx));
            check("full", 32'(bus.full), 32'(emitted >= N));
            emitted++;
         end
      end
   end

   initial begin
      rst = 1'b1;
      restart = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b1;
      #12;
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset out_data", bus.out_data, 32'd0);
      check("reset out_index", 32'(bus.out_index), 32'd0);
      check("reset full", 32'(bus.full), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      push(32'h00000001);
      send(32'h00400091);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      check("latency", 32'(lat), 32'd9);
      drain();
      push(32'h00000000);
      send(32'h00000000);
      drain();
      push(32'h12DD9BB3);
      send(32'hFFFFFFFF);
      drain();
      bus.out_ready = 1'b0;
      push(32'h12345678);
      send(temper(32'h12345678));
      repeat (9) @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold out_valid", 32'(bus.out_valid), 32'd1);
         check("hold out_data", bus.out_data, 32'h12345678);
         check("hold out_index", 32'(bus.out_index), 32'd3);
         check("hold in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();
      for (int i = 0; i < 1000; i++) begin
         automatic logic [31:0] r = $urandom;
         push(r);
         send(temper(r));
      end
      drain();
      check("full after wrap", 32'(bus.full), 32'd1);
      check("scoreboard empty", 32'(sb.size()), 32'd0);
      send(32'hCAFEBABE);
      repeat (3) @(posedge clk);
      #1;
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
      exp_idx = 0;
      check("restart in_ready", 32'(bus.in_ready), 32'd1);
      check("restart out_valid", 32'(bus.out_valid), 32'd0);
      check("restart out_index", 32'(bus.out_index), 32'd0);
      check("restart full", 32'(bus.full), 32'd0);
      check("restart out_data", bus.out_data, 32'd0);
      repeat (15) @(posedge clk);
      #1;
      check("no output after restart", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;
      send(32'h0BADF00D);
      repeat (9) @(posedge clk);
      #1;
      check("in OUT before rst", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("rst in_ready", 32'(bus.in_ready), 32'd1);
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst out_data", bus.out_data, 32'd0);
      check("rst out_index", 32'(bus.out_index), 32'd0);
      check("rst full", 32'(bus.full), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      push(32'hDEADBEEF);
      send(temper(32'hDEADBEEF));
      drain();
      check("final scoreboard empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
